// File: rtl/ltl_cluster_reporter.sv
// Collects per-property LTL automaton reports into registered hit/sticky flags and
// queues timestamped event records (one pending slot per property) through a small FIFO.
module ltl_cluster_reporter #(
    parameter int unsigned NUM_PROP   = 11,
    parameter int unsigned NUM_REPORT = 4,
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TS_W       = 16,
    localparam int unsigned PID_W     = (NUM_PROP > 1) ? $clog2(NUM_PROP) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           run,
    input  logic [SYM_W-1:0]               symbols,
    input  logic [NUM_PROP*NUM_REPORT-1:0] match,
    input  logic [NUM_PROP-1:0]            prop_en,
    input  logic                           clear,
    output logic [NUM_PROP-1:0]            ltl,
    output logic [NUM_PROP-1:0]            sticky,
    output logic                           overflow,
    output logic                           evt_valid,
    input  logic                           evt_ready,
    output logic [PID_W-1:0]               evt_prop,
    output logic [TS_W-1:0]                evt_stamp,
    output logic [SYM_W-1:0]               evt_symbol
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = PID_W + TS_W + SYM_W;

    logic [NUM_PROP-1:0] hit, grant, pending_q, pending_d, sticky_q, ltl_q;
    logic [TS_W-1:0]     ts_q;
    logic [TS_W-1:0]     stamp_q [NUM_PROP];
    logic [SYM_W-1:0]    sym_q [NUM_PROP];
    logic                overflow_q, ovf_set;
    logic [EW-1:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wptr_q, rptr_q;
    logic [CW-1:0]       count_q;
    logic                push, pop, can_push;
    logic [EW-1:0]       push_data;

    always_comb begin
        hit = '0;
        for (int p = 0; p < int'(NUM_PROP); p++) begin
            hit[p] = run & prop_en[p] & (|match[p*NUM_REPORT +: NUM_REPORT]);
        end
    end

    assign pop      = (count_q != '0) & evt_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign can_push = (count_q < CW'(FIFO_DEPTH)) | pop;

    always_comb begin
        grant     = '0;
        push      = 1'b0;
        push_data = '0;
        for (int p = 0; p < int'(NUM_PROP); p++) begin
            if (can_push && pending_q[p] && !push) begin
                grant[p]  = 1'b1;
                push      = 1'b1;
                push_data = {PID_W'(p), stamp_q[p], sym_q[p]};
            end
        end
    end

    // A granted slot is free again this cycle, so a same-cycle hit re-arms it cleanly.
    assign pending_d = hit | (pending_q & ~grant);
    assign ovf_set   = |(hit & pending_q & ~grant);

    always_ff @(posedge clk) begin
        if (reset) begin
            ltl_q      <= '0;
            sticky_q   <= '0;
            overflow_q <= 1'b0;
            pending_q  <= '0;
            ts_q       <= '0;
            for (int p = 0; p < int'(NUM_PROP); p++) begin
                stamp_q[p] <= '0;
                sym_q[p]   <= '0;
            end
        end else begin
            ltl_q      <= hit;
            sticky_q   <= (clear ? '0 : sticky_q) | hit;
            overflow_q <= (clear ? 1'b0 : overflow_q) | ovf_set;
            pending_q  <= pending_d;
            if (run) ts_q <= ts_q + 1'b1;
            for (int p = 0; p < int'(NUM_PROP); p++) begin
                if (hit[p] && (!pending_q[p] || grant[p])) begin
                    stamp_q[p] <= ts_q;
                    sym_q[p]   <= symbols;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    assign ltl        = ltl_q;
    assign sticky     = sticky_q;
    assign overflow   = overflow_q;
    assign evt_valid  = (count_q != '0);
    assign evt_prop   = mem_q[rptr_q][EW-1 -: PID_W];
    assign evt_stamp  = mem_q[rptr_q][SYM_W +: TS_W];
    assign evt_symbol = mem_q[rptr_q][SYM_W-1:0];

endmodule

// File: doc/ltl_cluster_reporter.md
LTL_CLUSTER_REPORTER -- requirements
Module: ltl_cluster_reporter

Interface
REQ-001 SHALL have parameter NUM_PROP, default 11: number of monitored LTL properties in the cluster.
REQ-002 SHALL have parameter NUM_REPORT, default 4: number of automaton report wires per property.
REQ-003 SHALL have parameter SYM_W, default 8: width of the trace symbol bus.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: event FIFO entries; power of two and at least 2.
REQ-005 SHALL have parameter TS_W, default 16: width of the timestamp counter. PID_W = max(1, clog2(NUM_PROP)).
REQ-006 SHALL have port clk, input, 1: the single clock; reset is synchronous and active-high.
REQ-007 SHALL have port reset, input, 1: synchronous, active-high.
REQ-008 SHALL have port run, input, 1: trace-step qualifier.
REQ-009 SHALL have port symbols, input, SYM_W: current trace symbol, latched into the event record.
REQ-010 SHALL have port match, input, NUM_PROP*NUM_REPORT: raw report wires; property p owns bits [p*NUM_REPORT +: NUM_REPORT].
REQ-011 SHALL have port prop_en, input, NUM_PROP: per-property enable mask.
REQ-012 SHALL have port clear, input, 1: clears sticky and overflow state.
REQ-013 SHALL have port ltl, output, NUM_PROP: registered per-cycle hit flags.
REQ-014 SHALL have port sticky, output, NUM_PROP: latched "ever hit" flags.
REQ-015 SHALL have port overflow, output, 1: latched flag for a lost event.
REQ-016 SHALL have ports evt_valid (output, 1) and evt_ready (input, 1): valid/ready event handshake.
REQ-017 SHALL have ports evt_prop (output, PID_W), evt_stamp (output, TS_W) and evt_symbol (output, SYM_W): the event record.

Function
REQ-018 SHALL compute hit[p] = run & prop_en[p] & OR of property p's NUM_REPORT match bits.
REQ-019 SHALL register ltl <= hit, giving 1-cycle latency.
REQ-020 SHALL increment the timestamp counter by 1 in every cycle with run=1, wrapping from 2^TS_W-1 to 0; it holds when run=0.
REQ-021 SHALL set sticky[p] on hit[p] and clear all sticky bits on clear; if hit[p] and clear occur in the same cycle, sticky[p]=1.
REQ-022 SHALL, on hit[p] with pending[p]=0, set pending[p] and capture stamp[p]=current counter (pre-increment value) and sym[p]=symbols.
REQ-023 SHALL, on hit[p] with pending[p]=1 and p not granted this cycle, drop the new hit, keep the original stamp/sym, and set overflow.
REQ-024 SHALL have the arbiter grant the lowest-index pending property when FIFO occupancy < FIFO_DEPTH, or when occupancy = FIFO_DEPTH and a pop occurs in the same cycle; at most one grant per cycle.
REQ-025 SHALL, on a grant, push {p, stamp[p], sym[p]} and clear pending[p]; a simultaneous new hit[p] re-arms pending[p] with the new stamp/sym and does not set overflow.
REQ-026 SHALL assert evt_valid iff the FIFO is non-empty; the evt_* record reflects the head entry and stays stable while evt_valid=1 and evt_ready=0.
REQ-027 SHALL pop the FIFO on evt_valid & evt_ready; push and pop in the same cycle leave occupancy unchanged.
REQ-028 SHALL clear overflow on clear, with set winning over a same-cycle clear; clear SHALL NOT affect pending bits or FIFO contents.
REQ-029 SHALL, with run=0, produce no hits while the FIFO and pending events continue draining.
REQ-030 SHALL add minimum event latency of 2 cycles: hit in cycle N gives pending in N+1, push in N+1, evt_valid in N+2.

Reset
REQ-031 SHALL, while reset=1 at a clk edge, zero ltl, sticky, overflow, pending, stamps, the timestamp counter and FIFO pointers/occupancy; evt_valid=0.
REQ-032 SHALL have reset take priority over all other inputs, including mid-handshake; FIFO contents are discarded.

Verification
REQ-033 SHALL cover: reset, then run=1, a match on property 2 bit 1 at counter=5 -> ltl[2]=1 for one cycle; evt_valid 2 cycles later with prop=2, stamp=5; sticky[2]=1.
REQ-034 SHALL cover: properties 0, 3 and 7 hit in one cycle with evt_ready=1 -> events emitted in order 0, 3, 7 with identical stamps, and no overflow.
REQ-035 SHALL cover: evt_ready=0, FIFO_DEPTH=4, six distinct properties hit -> 4 events queued, 2 pending; a second hit on a pending property -> overflow=1; then evt_ready=1 -> all 6 original stamps delivered.
REQ-036 SHALL cover: prop_en[4]=0 with a match on property 4 -> no ltl, sticky or event; run=0 with all matches high -> counter frozen and no hits.
REQ-037 SHALL cover: clear in the same cycle as hit[1] -> sticky[1]=1 and all other sticky bits=0; reset asserted while evt_valid=1 -> evt_valid=0 on the next cycle.
REQ-038 SHALL cover: counter preloaded to 0xFFFF via run cycles, then a hit -> stamp=0xFFFF, and the next cycle's stamp reads 0x0000.
